// File: rtl/mem_stage_dm_if.sv
// EX/MEM-to-WB bundle for the MEM stage: request fields in, registered WB fields out.
// master = upstream/driver side, slave = the MEM stage itself.
interface mem_stage_dm_if;
  logic [31:0] ao_m;
  logic [31:0] wdm_m;
  logic [31:0] pc_m;
  logic [31:0] pcadd8_m;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  mem_op;
  logic [4:0]  wr_reg_m;
  logic        reg_we_m;

  logic [31:0] ao_w;
  logic [31:0] dr_w;
  logic [31:0] pc_w;
  logic [31:0] pcadd8_w;
  logic [4:0]  wr_reg_w;
  logic        reg_we_w;
  logic        adel_w;
  logic        ades_w;

  modport master (
    output ao_m, wdm_m, pc_m, pcadd8_m, mem_we, mem_re, mem_op, wr_reg_m, reg_we_m,
    input  ao_w, dr_w, pc_w, pcadd8_w, wr_reg_w, reg_we_w, adel_w, ades_w
  );

  modport slave (
    input  ao_m, wdm_m, pc_m, pcadd8_m, mem_we, mem_re, mem_op, wr_reg_m, reg_we_m,
    output ao_w, dr_w, pc_w, pcadd8_w, wr_reg_w, reg_we_w, adel_w, ades_w
  );
endinterface

// File: rtl/mem_stage_dm.sv
// MEM stage: byte/half/word data memory with fault detection, plus the MEM/WB register (1-cycle latency).
// Optional DM_STORE_LOG_EN compiles in a simulation-only log line for each successful store.
module mem_stage_dm #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_dm_if.slave  bus
);

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] ao_q, dr_q, pc_q, pcadd8_q;
  logic [4:0]  wr_reg_q;
  logic        reg_we_q, adel_q, ades_q;
  logic [31:0] ao_d, dr_d, pc_d, pcadd8_d;
  logic [4:0]  wr_reg_d;
  logic        reg_we_d, adel_d, ades_d;

  size_e             size;
  logic              sign_ext;
  logic              misaligned, out_of_range, fault;
  logic              is_store, is_load, store_ok;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word, wr_word, ld_val;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign idx     = bus.ao_m[ADDR_W+1:2];
  assign lane    = bus.ao_m[1:0];
  assign rd_word = mem_q[idx];

  always_comb begin
    size     = SZ_WORD;
    sign_ext = 1'b0;
    case (bus.mem_op)
      3'b001: size = SZ_HALF;
      3'b010: begin size = SZ_HALF; sign_ext = 1'b1; end
      3'b011: size = SZ_BYTE;
      3'b100: begin size = SZ_BYTE; sign_ext = 1'b1; end
      default: size = SZ_WORD;
    endcase
  end

  always_comb begin
    misaligned   = ((size == SZ_WORD) && (lane != 2'b00)) ||
                   ((size == SZ_HALF) && lane[0]);
    out_of_range = {1'b0, bus.ao_m} >= MEM_BYTES;
    fault        = misaligned || out_of_range;
    // A simultaneous load+store request is treated purely as a store.
    is_store     = bus.mem_we;
    is_load      = bus.mem_re && !bus.mem_we;
    store_ok     = is_store && !fault;
  end

  // Merge the store data into the current word so untouched lanes keep their value.
  always_comb begin
    wr_word = rd_word;
    case (size)
      SZ_HALF: begin
        if (lane[1]) wr_word[31:16] = bus.wdm_m[15:0];
        else         wr_word[15:0]  = bus.wdm_m[15:0];
      end
      SZ_BYTE: wr_word[{3'b000, lane} * 8 +: 8] = bus.wdm_m[7:0];
      default: wr_word = bus.wdm_m;
    endcase
  end

  always_comb begin
    ld_byte = rd_word[{3'b000, lane} * 8 +: 8];
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_HALF: ld_val = {{16{sign_ext & ld_half[15]}}, ld_half};
      SZ_BYTE: ld_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      default: ld_val = rd_word;
    endcase
  end

  always_comb begin
    ao_d     = bus.ao_m;
    pc_d     = bus.pc_m;
    pcadd8_d = bus.pcadd8_m;
    wr_reg_d = bus.wr_reg_m;
    adel_d   = is_load && fault;
    ades_d   = is_store && fault;
    dr_d     = (is_load && !fault) ? ld_val : 32'd0;
    reg_we_d = bus.reg_we_m && !adel_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (store_ok) begin
      mem_q[idx] <= wr_word;
`ifdef DM_STORE_LOG_EN
      $display("@%h: *%h <= %h", bus.pc_m, {bus.ao_m[31:2], 2'b00}, wr_word);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ao_q     <= 32'd0;
      dr_q     <= 32'd0;
      pc_q     <= 32'd0;
      pcadd8_q <= 32'd0;
      wr_reg_q <= 5'd0;
      reg_we_q <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
    end else begin
      ao_q     <= ao_d;
      dr_q     <= dr_d;
      pc_q     <= pc_d;
      pcadd8_q <= pcadd8_d;
      wr_reg_q <= wr_reg_d;
      reg_we_q <= reg_we_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
    end
  end

  assign bus.ao_w     = ao_q;
  assign bus.dr_w     = dr_q;
  assign bus.pc_w     = pc_q;
  assign bus.pcadd8_w = pcadd8_q;
  assign bus.wr_reg_w = wr_reg_q;
  assign bus.reg_we_w = reg_we_q;
  assign bus.adel_w   = adel_q;
  assign bus.ades_w   = ades_q;

endmodule
